// File: rtl/tcn_shiftmem_writer.sv
// Producer side of the TCN shift memory: packs a valid/ready word stream into lane-prefix groups
// that never cross the depth wrap, and drives flush/set_depth/save_enable to the memory.
module tcn_shiftmem_writer #(
    parameter int DEPTH               = 48,
    parameter int PHYSICALBITSPERWORD = 80,
    parameter int WEIGHT_STAGGER      = 2
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  start_i,
    input  logic                                                  cfg_flush_i,
    input  logic [$clog2(DEPTH)-1:0]                              cfg_depth_i,
    input  logic                                                  word_valid_i,
    output logic                                                  word_ready_o,
    input  logic [PHYSICALBITSPERWORD-1:0]                        word_data_i,
    input  logic                                                  word_last_i,
    output logic [0:WEIGHT_STAGGER-1][PHYSICALBITSPERWORD-1:0]    data_o,
    output logic [0:WEIGHT_STAGGER-1]                             save_enable_o,
    output logic                                                  flush_o,
    output logic                                                  set_depth_o,
    output logic [$clog2(DEPTH)-1:0]                              read_depth_o,
    output logic [$clog2(DEPTH)-1:0]                              write_depth_o,
    output logic [$clog2(DEPTH+1)-1:0]                            words_written_o,
    output logic                                                  window_full_o,
    output logic                                                  busy_o,
    output logic                                                  done_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = $clog2(WEIGHT_STAGGER + 1);
    localparam int WS     = WEIGHT_STAGGER;
    localparam int PBPW   = PHYSICALBITSPERWORD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic                        cfg_flush_q, cfg_flush_d;
    logic [PTR_W-1:0]            cfg_depth_q, cfg_depth_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [LANE_W-1:0]           k_q, k_d;
    logic [0:WS-1][PBPW-1:0]     stage_q, stage_d;
    logic [CNT_W-1:0]            ww_q, ww_d;
    logic [0:WS-1]               out_en_q, out_en_d;
    logic [0:WS-1][PBPW-1:0]     out_data_q, out_data_d;
    logic                        done_q, done_d;

    logic                        accept;
    logic [CNT_W-1:0]            room;
    logic [LANE_W-1:0]           limit;
    logic [LANE_W-1:0]           n_words;
    logic [CNT_W:0]              ptr_sum;
    logic [CNT_W:0]              ww_sum;

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        cfg_flush_d = cfg_flush_q;
        cfg_depth_d = cfg_depth_q;
        ptr_d       = ptr_q;
        k_d         = k_q;
        stage_d     = stage_q;
        ww_d        = ww_q;
        out_en_d    = '0;
        out_data_d  = '0;
        done_d      = (state_q == S_DONE);

        accept  = word_valid_i && (state_q == S_RUN);
        room    = CNT_W'(DEPTH) - CNT_W'(ptr_q);
        limit   = (room < CNT_W'(WS)) ? LANE_W'(room) : LANE_W'(WS);
        n_words = k_q + LANE_W'(1);
        ptr_sum = (CNT_W + 1)'(ptr_q) + (CNT_W + 1)'(n_words);
        ww_sum  = (CNT_W + 1)'(ww_q) + (CNT_W + 1)'(n_words);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cfg_flush_d = cfg_flush_i;
                    cfg_depth_d = cfg_depth_i;
                    state_d     = S_INIT;
                end
            end
            S_INIT: begin
                ptr_d   = cfg_depth_q;
                k_d     = '0;
                ww_d    = '0;
                stage_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    for (int i = 0; i < WS; i++) begin
                        if (LANE_W'(i) == k_q) stage_d[i] = word_data_i;
                    end
                    // Close at the lane limit (which shrinks near the wrap) or on the last word;
                    // the group moves to the issue register so collection restarts immediately.
                    if ((n_words == limit) || word_last_i) begin
                        for (int i = 0; i < WS; i++) begin
                            if (LANE_W'(i) < n_words) begin
                                out_en_d[i]   = 1'b1;
                                out_data_d[i] = stage_d[i];
                            end
                        end
                        stage_d = '0;
                        k_d     = '0;
                        ptr_d   = (ptr_sum >= (CNT_W + 1)'(DEPTH))
                                  ? PTR_W'(ptr_sum - (CNT_W + 1)'(DEPTH))
                                  : PTR_W'(ptr_sum);
                        ww_d    = (ww_sum > (CNT_W + 1)'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(ww_sum);
                        if (word_last_i) state_d = S_DONE;
                    end else begin
                        k_d = n_words;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the staging buffer is plain
    // flops, so it is reset with everything else and a half-built group is discarded on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cfg_flush_q <= 1'b0;
            cfg_depth_q <= '0;
            ptr_q       <= '0;
            k_q         <= '0;
            stage_q     <= '0;
            ww_q        <= '0;
            out_en_q    <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_flush_q <= cfg_flush_d;
            cfg_depth_q <= cfg_depth_d;
            ptr_q       <= ptr_d;
            k_q         <= k_d;
            stage_q     <= stage_d;
            ww_q        <= ww_d;
            out_en_q    <= out_en_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign word_ready_o    = (state_q == S_RUN);
    assign busy_o          = (state_q != S_IDLE);
    assign set_depth_o     = (state_q == S_INIT);
    assign flush_o         = (state_q == S_INIT) && cfg_flush_q;
    assign read_depth_o    = cfg_depth_q;
    assign write_depth_o   = cfg_depth_q;
    assign data_o          = out_data_q;
    assign save_enable_o   = out_en_q;
    assign words_written_o = ww_q;
    assign window_full_o   = (ww_q == CNT_W'(DEPTH));
    assign done_o          = done_q;

endmodule

// File: tb/tb_tcn_shiftmem_writer.sv
// Self-checking bench for tcn_shiftmem_writer: table of sequences plus hand-written reset cases;
// expected groups are queued at drive time and popped when save_enable_o fires.
module tb_tcn_shiftmem_writer;

    localparam int DEPTH = 48;
    localparam int PBPW  = 80;
    localparam int WS    = 2;

    logic                       clk_i = 1'b0;
    logic                       rst_i = 1'b1;
    logic                       start_i = 1'b0;
    logic                       cfg_flush_i = 1'b0;
    logic [5:0]                 cfg_depth_i = '0;
    logic                       word_valid_i = 1'b0;
    logic                       word_ready_o;
    logic [PBPW-1:0]            word_data_i = '0;
    logic                       word_last_i = 1'b0;
    logic [0:WS-1][PBPW-1:0]    data_o;
    logic [0:WS-1]              save_enable_o;
    logic                       flush_o;
    logic                       set_depth_o;
    logic [5:0]                 read_depth_o;
    logic [5:0]                 write_depth_o;
    logic [5:0]                 words_written_o;
    logic                       window_full_o;
    logic                       busy_o;
    logic                       done_o;

    tcn_shiftmem_writer #(
        .DEPTH(DEPTH), .PHYSICALBITSPERWORD(PBPW), .WEIGHT_STAGGER(WS)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cfg_flush_i(cfg_flush_i),
        .cfg_depth_i(cfg_depth_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
        .word_data_i(word_data_i), .word_last_i(word_last_i), .data_o(data_o),
        .save_enable_o(save_enable_o), .flush_o(flush_o), .set_depth_o(set_depth_o),
        .read_depth_o(read_depth_o), .write_depth_o(write_depth_o),
        .words_written_o(words_written_o), .window_full_o(window_full_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [0:WS-1]            en;
        logic [0:WS-1][PBPW-1:0]  data;
    } grp_t;

    typedef struct {
        int depth;
        bit flush;
        int nwords;
        int gap;
        int exp_ww;
        bit exp_full;
    } vec_t;

    grp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [WS*PBPW-1:0] act,
                         input logic [WS*PBPW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every issued group must match the oldest expected one.
    always @(negedge clk_i) begin
        if (mon_en && save_enable_o != '0) begin
            check("flush_with_group", {159'd0, flush_o}, '0);
            if (exp_q.size() == 0) begin
                check("unexpected_group", {158'd0, save_enable_o}, '0);
            end else begin
                grp_t g;
                g = exp_q.pop_front();
                check("group_enable", {158'd0, save_enable_o}, {158'd0, g.en});
                check("group_data", data_o, g.data);
            end
        end
    end

    task automatic run_seq(input vec_t v, input string tag);
        int                      mptr;
        int                      k;
        grp_t                    cur;
        logic [PBPW-1:0]         w;
        int                      lim;
        start_i     = 1'b1;
        cfg_depth_i = 6'(v.depth);
        cfg_flush_i = v.flush;
        @(negedge clk_i);
        start_i     = 1'b0;
        cfg_flush_i = 1'b0;
        cfg_depth_i = '0;
        check({tag, "_set_depth"}, {159'd0, set_depth_o}, 1);
        check({tag, "_flush"}, {159'd0, flush_o}, {159'd0, v.flush});
        check({tag, "_read_depth"}, {154'd0, read_depth_o}, 160'(v.depth));
        check({tag, "_write_depth"}, {154'd0, write_depth_o}, 160'(v.depth));
        check({tag, "_init_not_ready"}, {159'd0, word_ready_o}, 0);
        @(negedge clk_i);
        check({tag, "_run_ready"}, {159'd0, word_ready_o}, 1);
        check({tag, "_run_no_set_depth"}, {159'd0, set_depth_o}, 0);
        mptr = v.depth;
        k    = 0;
        cur  = '0;
        for (int i = 0; i < v.nwords; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    word_valid_i = 1'b0;
                    @(negedge clk_i);
                end
            end
            w = {$urandom(), $urandom(), 16'($urandom())};
            word_valid_i = 1'b1;
            word_data_i  = w;
            word_last_i  = (i == v.nwords - 1);
            cur.en[k]    = 1'b1;
            cur.data[k]  = w;
            k++;
            lim = (DEPTH - mptr < WS) ? DEPTH - mptr : WS;
            if (k == lim || word_last_i) begin
                exp_q.push_back(cur);
                mptr = (mptr + k) % DEPTH;
                k    = 0;
                cur  = '0;
            end
            @(negedge clk_i);
        end
        word_valid_i = 1'b0;
        word_last_i  = 1'b0;
        check({tag, "_done_not_early"}, {159'd0, done_o}, 0);
        check({tag, "_busy_in_done"}, {159'd0, busy_o}, 1);
        @(negedge clk_i);
        check({tag, "_done_pulse"}, {159'd0, done_o}, 1);
        check({tag, "_idle"}, {159'd0, busy_o}, 0);
        check({tag, "_words_written"}, {154'd0, words_written_o}, 160'(v.exp_ww));
        check({tag, "_window_full"}, {159'd0, window_full_o}, {159'd0, v.exp_full});
        @(negedge clk_i);
        check({tag, "_done_single"}, {159'd0, done_o}, 0);
        check({tag, "_queue_drained"}, 160'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{depth: 5,  flush: 1'b1, nwords: 4,  gap: 0, exp_ww: 4,  exp_full: 1'b0};
        vecs[1] = '{depth: 47, flush: 1'b0, nwords: 3,  gap: 0, exp_ww: 3,  exp_full: 1'b0};
        vecs[2] = '{depth: 0,  flush: 1'b0, nwords: 1,  gap: 0, exp_ww: 1,  exp_full: 1'b0};
        vecs[3] = '{depth: 0,  flush: 1'b0, nwords: 50, gap: 0, exp_ww: 48, exp_full: 1'b1};
        vecs[4] = '{depth: 46, flush: 1'b0, nwords: 5,  gap: 1, exp_ww: 5,  exp_full: 1'b0};
        vecs[5] = '{depth: 10, flush: 1'b1, nwords: 3,  gap: 3, exp_ww: 3,  exp_full: 1'b0};

        repeat (3) @(negedge clk_i);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_i);
        check("rst_save_enable", {158'd0, save_enable_o}, '0);
        check("rst_data", data_o, '0);
        check("rst_flush", {159'd0, flush_o}, 0);
        check("rst_set_depth", {159'd0, set_depth_o}, 0);
        check("rst_busy", {159'd0, busy_o}, 0);
        check("rst_ready", {159'd0, word_ready_o}, 0);
        check("rst_done", {159'd0, done_o}, 0);
        check("rst_words", {154'd0, words_written_o}, 0);

        // Reset with one word staged: the partial group must never be issued.
        start_i     = 1'b1;
        cfg_depth_i = 6'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        word_valid_i = 1'b1;
        word_data_i  = 80'h1234_5678_9abc_def0_1111;
        word_last_i  = 1'b0;
        @(negedge clk_i);
        word_valid_i = 1'b0;
        check("staged_busy", {159'd0, busy_o}, 1);
        rst_i = 1'b1;
        #1;
        check("midrst_busy", {159'd0, busy_o}, 0);
        check("midrst_ready", {159'd0, word_ready_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("postrst_save_enable", {158'd0, save_enable_o}, '0);
            check("postrst_busy", {159'd0, busy_o}, 0);
            check("postrst_ready", {159'd0, word_ready_o}, 0);
        end

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk_i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
